// File: rtl/ysyx_25030081_imem_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Holds the FSM encoding, the LFSR seed and the latency bounds.
package ysyx_25030081_imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [7:0] LFSR_SEED   = 8'hA5;
    localparam int         MAX_LATENCY = 15;
    localparam int         EXTRA_MAX   = 3;
    // Wide enough for MAX_LATENCY-1 plus the largest random extra.
    localparam int         CNT_WIDTH   = $clog2(MAX_LATENCY + EXTRA_MAX + 1);

    // Feedback bit for x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB.
    function automatic logic lfsr8_fb(input logic [7:0] s);
        return s[7] ^ s[5] ^ s[4] ^ s[3];
    endfunction

endpackage

// File: rtl/ysyx_25030081_lfsr8.sv
// 8-bit Fibonacci LFSR that advances once per asserted step.
// Used only to jitter fetch latency when IMEM_RAND_DELAY_EN is defined.
module ysyx_25030081_lfsr8
    import ysyx_25030081_imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= LFSR_SEED;
        end else if (step) begin
            q <= {q[6:0], lfsr8_fb(q)};
        end
    end

endmodule

// File: rtl/ysyx_25030081_imem_resp.sv
// Instruction-fetch responder: one outstanding fetch, programmable latency, preloadable store.
// Define IMEM_RAND_DELAY_EN to add 0..3 LFSR-chosen wait cycles per accepted fetch.
module ysyx_25030081_imem_resp
    import ysyx_25030081_imem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_inst,
    output logic                  resp_err,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int                   DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(LATENCY - 1);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, cnt_load;
    logic [ADDR_WIDTH-1:0]   addr_q, fetch_addr;
    logic [ADDR_WIDTH-3:0]   off_word;
    logic [DEPTH_LOG2-1:0]   word_idx;
    logic                    fetch_err;
    logic                    accept;
    logic                    capture;
    logic [1:0]              extra;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign accept     = (state_q == ST_IDLE) && req_valid;
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);

`ifdef IMEM_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    ysyx_25030081_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (accept),
        .q    (lfsr_q)
    );

    assign extra = lfsr_q[1:0];
`else
    assign extra = 2'b00;
`endif

    assign cnt_load = CNT_INIT + CNT_WIDTH'(extra);

    // With zero remaining wait the array is read on the accept edge, before addr_q holds the address.
    assign fetch_addr = (state_q == ST_IDLE) ? req_addr : addr_q;
    // BASE_ADDR is word aligned, so the offset can be formed on word addresses alone.
    assign off_word   = fetch_addr[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
    assign fetch_err  = (fetch_addr[1:0] != 2'b00) || (off_word[ADDR_WIDTH-3:DEPTH_LOG2] != '0);
    assign word_idx   = off_word[DEPTH_LOG2-1:0];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_d = cnt_load;
                    if (cnt_load == '0) begin
                        state_d = ST_RESP;
                        capture = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = ST_RESP;
                    capture = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments give read-before-write: a load landing on the capture edge is not seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            resp_inst <= '0;
            resp_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= req_addr;
            end
            if (capture) begin
                resp_err  <= fetch_err;
                resp_inst <= fetch_err ? '0 : mem[word_idx];
            end
        end
    end

    // NOTE: the storage array has no reset; preloaded contents must survive a core reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule
